rr_arbiter_n: RTL and testbench

//   Parametrised N-requester arbiter; successor to the 2-port arb_if arbiter.

---
 rtl/rr_arbiter_n.sv | 133 +++++++++++++
 tb/tb_rr_arbiter_n.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester arbiter with a registered one-hot grant.
// Selection is either round-robin or fixed priority, where index 0 is highest.
// The owner keeps the grant while its request stays high. When HOLD_MAX is
// non-zero, a hold timeout forces rotation if other requesters are waiting.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   request      per-requester request vector
//   grant        registered one-hot grant, zero when idle
//   grant_valid  registered |grant
//   grant_id     registered binary index of the owner, 0 when idle
//   preempt      one-cycle pulse after a timeout rotation
module rr_arbiter_n #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned RR_MODE  = 1,
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] request,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  output logic             preempt
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] HOLD_SAT = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic             r_valid;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_rr_ptr;
  logic [CW-1:0]    r_hold_cnt;
  logic             r_preempt;

  logic [N_REQ-1:0] w_owner_mask;
  logic [N_REQ-1:0] w_cand;
  logic [IDW:0]     w_pick;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [N_REQ-1:0] w_win_onehot;
  logic [IDW-1:0]   w_next_ptr;
  logic [IDW:0]     w_ptr_inc;
  logic             w_own_req;
  logic             w_timeout;

  // Returns {found, index}. In round-robin mode the search starts at ptr and wraps.
  function automatic logic [IDW:0] pick_winner(input logic [N_REQ-1:0] cand,
                                               input logic [IDW-1:0]   ptr);
    logic [IDW:0] res;
    logic [IDW:0] s;
    res = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (RR_MODE != 0) s = {1'b0, ptr} + (IDW+1)'(k);
      else              s = (IDW+1)'(k);
      if (s >= (IDW+1)'(N_REQ)) s = s - (IDW+1)'(N_REQ);
      if (!res[IDW] && cand[IDW'(s)]) res = {1'b1, IDW'(s)};
    end
    return res;
  endfunction

  // The current owner is never a candidate, for either a drop or a timeout.
  assign w_owner_mask = (r_state == S_GRANT) ? r_grant : '0;
  assign w_cand       = request & ~w_owner_mask;
  assign w_pick       = pick_winner(w_cand, r_rr_ptr);
  assign w_found      = w_pick[IDW];
  assign w_win        = w_pick[IDW-1:0];
  assign w_win_onehot = N_REQ'(1) << w_win;
  assign w_ptr_inc    = {1'b0, w_win} + (IDW+1)'(1);
  assign w_next_ptr   = (w_ptr_inc >= (IDW+1)'(N_REQ)) ? '0 : w_ptr_inc[IDW-1:0];
  assign w_own_req    = |(request & r_grant);
  assign w_timeout    = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_SAT) && (|w_cand);

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_GRANT;
            r_grant    <= w_win_onehot;
            r_valid    <= 1'b1;
            r_id       <= w_win;
            r_hold_cnt <= '0;
            if (RR_MODE != 0) r_rr_ptr <= w_next_ptr;
          end
        end
        S_GRANT: begin
          if (!w_own_req || w_timeout) begin
            if (w_found) begin
              // Hand over on this edge, so there is no idle bubble between owners.
              r_grant    <= w_win_onehot;
              r_valid    <= 1'b1;
              r_id       <= w_win;
              r_hold_cnt <= '0;
              r_preempt  <= w_own_req;
              if (RR_MODE != 0) r_rr_ptr <= w_next_ptr;
            end else begin
              r_state    <= S_IDLE;
              r_grant    <= '0;
              r_valid    <= 1'b0;
              r_id       <= '0;
              r_hold_cnt <= '0;
            end
          end else if (r_hold_cnt != HOLD_SAT) begin
            r_hold_cnt <= r_hold_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_id    = r_id;
  assign preempt     = r_preempt;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: three arbiter configurations share a single request stream.
// A reference model pushes the expected outputs for each configuration into a
// queue when the request is driven, and the entry is popped and compared after
// the next clock edge.
//   u_a: round-robin, HOLD_MAX=4
//   u_b: fixed priority, no hold limit
//   u_c: round-robin, no hold limit
module tb_rr_arbiter_n;

  logic       clk;
  logic       reset;
  logic [3:0] req;

  logic [3:0] g_a, g_b, g_c;
  logic       v_a, v_b, v_c;
  logic [1:0] id_a, id_b, id_c;
  logic       p_a, p_b, p_c;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic busy;
    int   owner;
    int   cnt;
    int   ptr;
    logic pre;
  } ms_t;

  ms_t m_a, m_b, m_c;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  rr_arbiter_n #(.N_REQ(4), .RR_MODE(1), .HOLD_MAX(4)) u_a (
    .clk(clk), .reset(reset), .request(req),
    .grant(g_a), .grant_valid(v_a), .grant_id(id_a), .preempt(p_a));
  rr_arbiter_n #(.N_REQ(4), .RR_MODE(0), .HOLD_MAX(0)) u_b (
    .clk(clk), .reset(reset), .request(req),
    .grant(g_b), .grant_valid(v_b), .grant_id(id_b), .preempt(p_b));
  rr_arbiter_n #(.N_REQ(4), .RR_MODE(1), .HOLD_MAX(0)) u_c (
    .clk(clk), .reset(reset), .request(req),
    .grant(g_c), .grant_valid(v_c), .grant_id(id_c), .preempt(p_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] cand, input int ptr, input int rr);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (rr != 0) ? (ptr + k) % 4 : k;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  function automatic ms_t step(input ms_t s, input logic [3:0] r, input int rr, input int hm);
    ms_t n;
    int w;
    logic [3:0] own;
    n = s;
    n.pre = 1'b0;
    own = s.busy ? 4'(1 << s.owner) : 4'b0;
    if (!s.busy || !r[s.owner]) begin
      w = pick(r & ~own, s.ptr, rr);
      if (w >= 0) begin
        n.busy = 1'b1; n.owner = w; n.cnt = 0; n.ptr = (w + 1) % 4;
      end else begin
        n.busy = 1'b0; n.owner = 0; n.cnt = 0;
      end
    end else if (hm != 0 && s.cnt == hm - 1 && (r & ~own) != 4'b0) begin
      w = pick(r & ~own, s.ptr, rr);
      n.owner = w; n.cnt = 0; n.ptr = (w + 1) % 4; n.pre = 1'b1;
    end else if (hm != 0 && s.cnt < hm - 1) begin
      n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] enc(input ms_t s);
    logic [7:0] e;
    e[3:0] = s.busy ? 4'(1 << s.owner) : 4'b0;
    e[5:4] = s.busy ? 2'(s.owner) : 2'b0;
    e[6]   = s.busy;
    e[7]   = s.pre;
    return e;
  endfunction

  function automatic ms_t ms_reset();
    ms_t s;
    s.busy = 1'b0; s.owner = 0; s.cnt = 0; s.ptr = 0; s.pre = 1'b0;
    return s;
  endfunction

  // Drive one request vector, predict the outputs and compare after the edge.
  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    req = r;
    m_a = step(m_a, r, 1, 4); q_a.push_back(enc(m_a));
    m_b = step(m_b, r, 0, 0); q_b.push_back(enc(m_b));
    m_c = step(m_c, r, 1, 0); q_c.push_back(enc(m_c));
    @(posedge clk);
    #1;
    check("sb_a", 32'({p_a, v_a, id_a, g_a}), 32'(q_a.pop_front()));
    check("sb_b", 32'({p_b, v_b, id_b, g_b}), 32'(q_b.pop_front()));
    check("sb_c", 32'({p_c, v_c, id_c, g_c}), 32'(q_c.pop_front()));
  endtask

  // Assert reset at a negedge, so the clear must be visible before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b1111;
    #1;
    check("rst_imm_a", 32'({p_a, v_a, id_a, g_a}), 32'h0);
    check("rst_imm_b", 32'({p_b, v_b, id_b, g_b}), 32'h0);
    check("rst_imm_c", 32'({p_c, v_c, id_c, g_c}), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_a", 32'({p_a, v_a, id_a, g_a}), 32'h0);
    @(negedge clk);
    req   = 4'b0000;
    reset = 1'b1;
    m_a = ms_reset(); m_b = ms_reset(); m_c = ms_reset();
  endtask

  logic [3:0] t3_req [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0] t3_g   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] t4_g   [9] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1};
  logic       t4_p   [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
  logic [3:0] t5_req [6] = '{4'b1110, 4'b1100, 4'b1110, 4'b1110, 4'b1110, 4'b1010};
  logic [3:0] t5_g   [6] = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010};

  initial begin
    logic [3:0] r;
    reset = 1'b0;
    req   = 4'b1111;
    m_a = ms_reset(); m_b = ms_reset(); m_c = ms_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_init_a", 32'({p_a, v_a, id_a, g_a}), 32'h0);
    do_reset();

    // Single request, then drop it, then reset while the grant is held.
    cycle(4'b0010);
    check("t2_grant", 32'(g_a), 32'h2);
    check("t2_id", 32'(id_a), 32'h1);
    cycle(4'b0000);
    check("t2_idle_grant", 32'(g_a), 32'h0);
    check("t2_idle_valid", 32'(v_a), 32'h0);
    cycle(4'b0010);
    do_reset();

    // Back-to-back round-robin handover.
    for (int i = 0; i < 4; i++) begin
      cycle(t3_req[i]);
      check("t3_grant", 32'(g_a), 32'(t3_g[i]));
    end
    cycle(4'b0000);
    do_reset();

    // Hold timeout rotation.
    for (int i = 0; i < 9; i++) begin
      cycle(4'b0101);
      check("t4_grant", 32'(g_a), 32'(t4_g[i]));
      check("t4_preempt", 32'(p_a), 32'(t4_p[i]));
    end
    repeat (6) cycle(4'b0101);
    do_reset();

    // Fixed priority: a higher-priority request does not take the grant from the owner.
    for (int i = 0; i < 6; i++) begin
      cycle(t5_req[i]);
      check("t5_grant", 32'(g_b), 32'(t5_g[i]));
    end
    do_reset();

    // No hold limit: the owner keeps the grant indefinitely.
    for (int i = 0; i < 100; i++) begin
      cycle(4'b0011);
      if (i % 10 == 0) check("t6_grant", 32'(g_c), 32'h1);
      check("t6_preempt", 32'(p_c), 32'h0);
    end
    do_reset();

    // Random stress with invariant checks.
    r = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 15));
      cycle(r);
      check("inv_onehot", 32'($onehot0(g_a)), 32'h1);
      check("inv_valid", 32'(v_a), 32'(|g_a));
      if (v_a) check("inv_id", 32'(g_a[id_a]), 32'h1);
      if (i == 150) do_reset();
    end
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
